// File: rtl/in_filter_pkg.sv
// Shared types for the input-conditioning controller.
package in_filter_pkg;

  // Widest channel index needed (up to 32 channels).
  localparam int unsigned MaxChanW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } in_filter_state_e;

  // Event handed to the consumer.
  typedef struct packed {
    logic [MaxChanW-1:0] chan;
    logic                rise;
  } in_filter_evt_t;

endpackage

// File: rtl/in_filter_chan.sv
// Per-channel glitch filter: tick history, stable level and edge detect.
module in_filter_chan #(
  parameter int unsigned Cycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_en,
  input  logic i_tick,
  input  logic i_s,
  output logic o_filt,
  output logic o_evt
);

  // Only the older Cycles-1 samples are stored; the oldest would shift out
  // before it is ever compared, so the window is completed by the live sample.
  logic [Cycles-2:0] r_hist;
  logic [Cycles-1:0] w_hist_d;
  logic              w_stable;
  logic              r_filt;

  // Candidate history and level-change detect.
  always_comb begin
    w_hist_d = {r_hist, i_s};
    w_stable = (w_hist_d == '0) || (w_hist_d == '1);
    o_evt    = i_en & i_tick & w_stable & (i_s != r_filt);
  end

  // Disabled channels track the input directly so enabling is event-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hist <= '0;
      r_filt <= 1'b0;
    end else if (!i_en) begin
      r_hist <= {(Cycles-1){i_s}};
      r_filt <= i_s;
    end else if (i_tick) begin
      r_hist <= w_hist_d[Cycles-2:0];
      if (w_stable) begin
        r_filt <= i_s;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for asynchronous inputs.
module prim_flop_2sync #(
  parameter int unsigned     Width      = 16,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  // Two register stages to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= ResetValue;
      r_sync <= ResetValue;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/in_filter_ctrl.sv
// Multi-channel input filter with shared prescaler and round-robin event port.
module in_filter_ctrl
  import in_filter_pkg::*;
#(
  parameter int unsigned NumChan = 8,
  parameter int unsigned Cycles  = 4,
  parameter int unsigned PrescW  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_we_i,
  input  logic [PrescW-1:0]          cfg_prescale_i,
  input  logic [NumChan-1:0]         cfg_en_i,
  input  logic [NumChan-1:0]         in_i,
  output logic [NumChan-1:0]         filt_o,
  output logic                       tick_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(NumChan)-1:0] evt_chan_o,
  output logic                       evt_rise_o,
  output logic [NumChan-1:0]         ovf_o
);

  localparam int unsigned ChanW = $clog2(NumChan);

  in_filter_state_e r_state, w_state_d;
  logic [PrescW-1:0]  r_prescale, r_cnt, w_cnt_d;
  logic [NumChan-1:0] r_en, r_pend, r_type, r_ovf;
  logic [NumChan-1:0] w_s, w_filt, w_evt, w_pop;
  logic [ChanW-1:0]   r_rr, r_lock_chan, w_search, w_grant, w_idx_c;
  logic               r_locked, w_found, w_valid, w_hs, w_clear, w_tick;
  int unsigned        w_idx;
  in_filter_evt_t     w_out;

  prim_flop_2sync #(
    .Width      (NumChan),
    .ResetValue ('0)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (in_i),
    .q_o    (w_s)
  );

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    in_filter_chan #(
      .Cycles (Cycles)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_en   (r_en[c]),
      .i_tick (w_tick),
      .i_s    (w_s[c]),
      .o_filt (w_filt[c]),
      .o_evt  (w_evt[c])
    );
  end

  // Configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prescale <= '0;
      r_en       <= '0;
    end else if (cfg_we_i) begin
      r_prescale <= cfg_prescale_i;
      r_en       <= cfg_en_i;
    end
  end

  // FSM state and prescaler counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next state, prescaler count and sample tick.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_tick    = 1'b0;
    unique case (r_state)
      IDLE: w_cnt_d = '0;
      ARM: begin
        w_state_d = RUN;
        w_cnt_d   = '0;
      end
      RUN: begin
        w_tick  = (r_cnt == r_prescale);
        w_cnt_d = w_tick ? '0 : r_cnt + PrescW'(1);
      end
      default: w_state_d = IDLE;
    endcase
    if (cfg_we_i) begin
      w_state_d = (cfg_en_i != '0) ? ARM : IDLE;
      w_cnt_d   = '0;
    end
  end

  // Round-robin search from rr pointer; grant is held while the consumer stalls.
  always_comb begin
    w_found  = 1'b0;
    w_search = '0;
    w_idx    = 0;
    w_idx_c  = '0;
    for (int unsigned i = 0; i < NumChan; i++) begin
      w_idx   = (32'(r_rr) + i) % NumChan;
      w_idx_c = ChanW'(w_idx);
      if (!w_found && r_pend[w_idx_c]) begin
        w_found  = 1'b1;
        w_search = w_idx_c;
      end
    end
    w_valid = |r_pend;
    w_grant = r_locked ? r_lock_chan : w_search;
    w_hs    = w_valid & evt_ready_i;
    w_clear = cfg_we_i | (r_state == ARM);
    w_pop   = '0;
    if (w_hs) begin
      w_pop[w_grant] = 1'b1;
    end
    w_out.chan = MaxChanW'(w_grant);
    w_out.rise = w_valid & r_type[w_grant];
  end

  // Pending events, event type and sticky overflow per channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_type <= '0;
      r_ovf  <= '0;
    end else if (w_clear) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      for (int unsigned c = 0; c < NumChan; c++) begin
        if (w_evt[c]) begin
          r_pend[c] <= 1'b1;
          r_type[c] <= w_s[c];
          if (r_pend[c] && !w_pop[c]) begin
            r_ovf[c] <= 1'b1;
          end
        end else if (w_pop[c]) begin
          r_pend[c] <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer and grant lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr        <= '0;
      r_locked    <= 1'b0;
      r_lock_chan <= '0;
    end else begin
      if (w_hs) begin
        r_rr <= (w_grant == ChanW'(NumChan - 1)) ? '0 : w_grant + ChanW'(1);
      end
      r_locked    <= w_valid & ~evt_ready_i & ~w_clear;
      r_lock_chan <= w_grant;
    end
  end

  assign filt_o      = w_filt;
  assign tick_o      = w_tick;
  assign evt_valid_o = w_valid;
  assign evt_chan_o  = ChanW'(w_out.chan);
  assign evt_rise_o  = w_out.rise;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_in_filter_ctrl.sv
// Self-checking bench for in_filter_ctrl with a behavioural reference model.
module tb_in_filter_ctrl;

  localparam int N  = 8;
  localparam int C  = 4;
  localparam int PW = 16;

  logic          clk, rst_n, cfg_we, tick, valid, ready, rise;
  logic [PW-1:0] cfg_p;
  logic [N-1:0]  cfg_en, in_v, filt, ovf;
  logic [2:0]    chan;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 0;
  int log_q[$];

  in_filter_ctrl #(
    .NumChan (N),
    .Cycles  (C),
    .PrescW  (PW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_we_i       (cfg_we),
    .cfg_prescale_i (cfg_p),
    .cfg_en_i       (cfg_en),
    .in_i           (in_v),
    .filt_o         (filt),
    .tick_o         (tick),
    .evt_valid_o    (valid),
    .evt_ready_i    (ready),
    .evt_chan_o     (chan),
    .evt_rise_o     (rise),
    .ovf_o          (ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0]  m_pipe0, m_pipe1, m_en, m_filt, m_last, m_pend, m_typ, m_ovf;
  int            m_run[N];
  logic [PW-1:0] m_P;
  int            m_mode;   // 0 idle, 1 arm, 2 run
  int            m_age;    // cycles since ARM
  int            m_rr, m_lkch;
  bit            m_lk;
  bit            e_tick, e_valid, e_rise;
  int            e_chan;

  task automatic m_present();
    e_tick  = (m_mode == 2) && (m_age % (int'(m_P) + 1) == 0);
    e_valid = (m_pend != '0);
    e_chan  = 0;
    e_rise  = 0;
    if (e_valid) begin
      if (m_lk) e_chan = m_lkch;
      else begin
        for (int i = N - 1; i >= 0; i--)
          if (m_pend[(m_rr + i) % N]) e_chan = (m_rr + i) % N;
      end
      e_rise = m_typ[e_chan];
    end
  endtask

  task automatic m_reset();
    m_pipe0 = '0; m_pipe1 = '0; m_en = '0; m_filt = '0; m_last = '0;
    m_pend = '0; m_typ = '0; m_ovf = '0; m_P = '0;
    m_mode = 0; m_age = 0; m_rr = 0; m_lk = 0; m_lkch = 0;
    for (int c = 0; c < N; c++) m_run[c] = C;
    m_present();
  endtask

  task automatic m_step();
    bit tk, hs, clr, ev;
    int g;
    logic [N-1:0] s;
    tk  = e_tick;
    hs  = e_valid && ready;
    g   = e_chan;
    clr = cfg_we || (m_mode == 1);
    s   = m_pipe1;
    for (int c = 0; c < N; c++) begin
      ev = 0;
      if (!m_en[c]) begin
        m_filt[c] = s[c]; m_last[c] = s[c]; m_run[c] = C;
      end else if (tk) begin
        if (s[c] == m_last[c]) begin
          if (m_run[c] < C) m_run[c]++;
        end else begin
          m_last[c] = s[c]; m_run[c] = 1;
        end
        if (m_run[c] >= C && m_filt[c] != s[c]) begin
          m_filt[c] = s[c]; ev = 1;
        end
      end
      if (clr) begin
        m_pend[c] = 0; m_ovf[c] = 0;
      end else if (ev) begin
        if (m_pend[c] && !(hs && g == c)) m_ovf[c] = 1;
        m_pend[c] = 1; m_typ[c] = s[c];
      end else if (hs && g == c) m_pend[c] = 0;
    end
    if (hs) m_rr = (g + 1) % N;
    m_lk   = e_valid && !ready && !clr;
    m_lkch = g;
    if (cfg_we) begin
      m_en = cfg_en; m_P = cfg_p; m_mode = (cfg_en != '0) ? 1 : 0; m_age = 0;
    end else if (m_mode == 1) begin
      m_mode = 2; m_age = 1;
    end else if (m_mode == 2) m_age++;
    m_pipe1 = m_pipe0;
    m_pipe0 = in_v;
    m_present();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // Per-cycle comparison and handshake log.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_filt", filt, m_filt);
      chk("m_tick", tick, e_tick);
      chk("m_valid", valid, e_valid);
      chk("m_ovf", ovf, m_ovf);
      if (e_valid) begin
        chk("m_chan", chan, e_chan);
        chk("m_rise", rise, e_rise);
      end
      if (valid && ready) log_q.push_back(int'(chan) * 2 + int'(rise));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [PW-1:0] p, input logic [N-1:0] en);
    cfg_p = p; cfg_en = en; cfg_we = 1;
    step();
    cfg_we = 0;
  endtask

  task automatic wait_log(input int n, input string nm);
    int k = 0;
    while (log_q.size() < n && k < 300) begin step(); k++; end
    chk(nm, 32'(log_q.size() >= n), 1);
  endtask

  task automatic wait_filt(input int c, input logic v, input string nm);
    int k = 0;
    while (filt[c] !== v && k < 300) begin step(); k++; end
    chk(nm, filt[c], v);
  endtask

  initial begin
    int tt[4];
    int ntick, k, lsz, seen;
    int exp_log[6];
    rst_n = 0; cfg_we = 0; cfg_p = '0; cfg_en = '0; in_v = '0; ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    run_cmp = 1;
    chk("rst_filt", filt, 0);
    chk("rst_tick", tick, 0);
    chk("rst_valid", valid, 0);
    chk("rst_chan", chan, 0);
    chk("rst_rise", rise, 0);
    chk("rst_ovf", ovf, 0);
    step();

    // Basic tick period and first filtered edge on channel 0.
    ready = 1;
    in_v[0] = 1;
    cfg_write(16'd3, 8'h01);
    ntick = 0; k = 0;
    while (ntick < 4 && k < 100) begin
      step(); k++;
      if (tick) begin tt[ntick] = k; ntick++; end
    end
    chk("t1_ntick", ntick, 4);
    chk("t1_first_tick", tt[0], 4);
    chk("t1_period", tt[1] - tt[0], 4);
    chk("t1_period2", tt[3] - tt[2], 4);
    chk("t1_filt_pre", filt[0], 0);
    step();
    chk("t1_filt_post", filt[0], 1);
    chk("t1_valid", valid, 1);
    chk("t1_chan", chan, 0);
    chk("t1_rise", rise, 1);
    repeat (3) step();
    chk("t1_log_n", log_q.size(), 1);
    chk("t1_log0", log_q[0], 1);

    // Short low glitch on channel 0 must be filtered out.
    lsz = log_q.size(); seen = 0;
    for (int i = 0; i < 48; i++) begin
      in_v[0] = !(i >= 2 && i < 8);
      step();
      if (filt[0] !== 1'b1) seen = 1;
    end
    chk("t2_filt_stable", seen, 0);
    chk("t2_no_evt", log_q.size(), lsz);

    // Disabled channel 3 follows its input, no events; enabling is silent.
    lsz = log_q.size();
    in_v[3] = 1;
    repeat (3) step();
    chk("t3_follow_hi", filt[3], 1);
    in_v[3] = 0;
    repeat (3) step();
    chk("t3_follow_lo", filt[3], 0);
    for (int i = 0; i < 6; i++) begin in_v[3] = i[0]; step(); end
    in_v[3] = 1;
    repeat (4) step();
    cfg_write(16'd3, 8'h09);
    repeat (40) step();
    chk("t3_no_evt", log_q.size(), lsz);
    chk("t3_filt", filt[3], 1);

    // Round-robin: rises on 1,2,5 then falls on 1,2 with pointer at 6.
    cfg_write(16'd3, 8'h27);
    lsz = log_q.size();
    in_v[1] = 1; in_v[2] = 1; in_v[5] = 1;
    wait_log(lsz + 3, "t4_wait_rise");
    in_v[1] = 0; in_v[2] = 0;
    wait_log(lsz + 5, "t4_wait_fall");
    exp_log = '{3, 5, 11, 2, 4, 0};
    for (int i = 0; i < 5; i++) chk($sformatf("t4_order%0d", i), log_q[lsz + i], exp_log[i]);

    // Overflow on channel 2 with consumer stalled; config write clears it.
    ready = 0;
    in_v[2] = 1;
    wait_filt(2, 1, "t5_wait_rise");
    in_v[2] = 0;
    wait_filt(2, 0, "t5_wait_fall");
    chk("t5_ovf", ovf[2], 1);
    chk("t5_valid", valid, 1);
    chk("t5_chan", chan, 2);
    chk("t5_rise", rise, 0);
    cfg_write(16'd3, 8'h27);
    chk("t5_clr_valid", valid, 0);
    chk("t5_clr_ovf", ovf, 0);

    // Prescale 0: tick every RUN cycle.
    cfg_write(16'd0, 8'h27);
    chk("t6_arm_tick", tick, 0);
    step();
    chk("t6_tick_a", tick, 1);
    step();
    chk("t6_tick_b", tick, 1);

    // Asynchronous reset with an event pending.
    in_v[5] = 0;
    k = 0;
    while (!valid && k < 50) begin step(); k++; end
    chk("t7_pending", valid, 1);
    #3;
    rst_n = 0;
    #1;
    chk("t7_filt", filt, 0);
    chk("t7_tick", tick, 0);
    chk("t7_valid", valid, 0);
    chk("t7_chan", chan, 0);
    chk("t7_rise", rise, 0);
    chk("t7_ovf", ovf, 0);
    repeat (2) step();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick || valid) seen++;
    end
    chk("t7_idle", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
